// File: rtl/fetch_pkg.sv
// Shared types and default widths for the instruction-fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    HOLD    = 2'd2,
    DISCARD = 2'd3
  } fetch_state_e;

  localparam int DEF_IWIDTH = 24;
  localparam int DEF_PWIDTH = 16;

endpackage

// File: rtl/fetch_skid.sv
// One-entry {instr, next_pc} buffer catching a fetch that lands while decode is stalled.
module fetch_skid
  import fetch_pkg::*;
#(
  parameter int IWIDTH = DEF_IWIDTH,
  parameter int PWIDTH = DEF_PWIDTH
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load,
  input  logic              unload,
  input  logic              clear,
  input  logic [IWIDTH-1:0] instr_in,
  input  logic [PWIDTH-1:0] next_pc_in,
  output logic              full,
  output logic [IWIDTH-1:0] instr,
  output logic [PWIDTH-1:0] next_pc
);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      full    <= 1'b0;
      instr   <= '0;
      next_pc <= '0;
    end else if (clear || unload) begin
      full    <= 1'b0;
      instr   <= '0;
      next_pc <= '0;
    end else if (load) begin
      full    <= 1'b1;
      instr   <= instr_in;
      next_pc <= next_pc_in;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, req/ack fetch FSM and the decode-side output register.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                IWIDTH   = DEF_IWIDTH,
  parameter int                PWIDTH   = DEF_PWIDTH,
  parameter logic [PWIDTH-1:0] RESET_PC = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  output logic              imem_req_o,
  output logic [PWIDTH-1:0] imem_addr_o,
  input  logic              imem_ack_i,
  input  logic [IWIDTH-1:0] imem_rdata_i,
  input  logic              stall_i,
  input  logic              redirect_i,
  input  logic [PWIDTH-1:0] redirect_pc_i,
  output logic              valid_o,
  output logic [IWIDTH-1:0] instr_o,
  output logic [PWIDTH-1:0] next_pc_o
);

  fetch_state_e      state_reg;
  logic [PWIDTH-1:0] pc_reg;
  logic [PWIDTH-1:0] discard_addr_reg;
  logic [PWIDTH-1:0] pc_inc;
  logic              out_stalled;
  logic              skid_load;
  logic              skid_unload;
  logic              skid_full;
  logic [IWIDTH-1:0] skid_instr;
  logic [PWIDTH-1:0] skid_next_pc;

  assign pc_inc      = pc_reg + PWIDTH'(1);
  assign out_stalled = valid_o && stall_i;
  assign imem_req_o  = (state_reg == REQ) || (state_reg == DISCARD);
  // An orphaned request keeps its original address until memory answers it.
  assign imem_addr_o = (state_reg == DISCARD) ? discard_addr_reg : pc_reg;
  assign skid_load   = !redirect_i && (state_reg == REQ) && imem_ack_i && out_stalled;
  assign skid_unload = !redirect_i && (state_reg == HOLD) && !stall_i;

  fetch_skid #(
    .IWIDTH (IWIDTH),
    .PWIDTH (PWIDTH)
  ) u_skid (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load       (skid_load),
    .unload     (skid_unload),
    .clear      (redirect_i),
    .instr_in   (imem_rdata_i),
    .next_pc_in (pc_inc),
    .full       (skid_full),
    .instr      (skid_instr),
    .next_pc    (skid_next_pc)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_reg        <= IDLE;
      pc_reg           <= RESET_PC;
      discard_addr_reg <= RESET_PC;
      valid_o          <= 1'b0;
      instr_o          <= '0;
      next_pc_o        <= '0;
    end else if (redirect_i) begin
      valid_o   <= 1'b0;
      instr_o   <= '0;
      next_pc_o <= '0;
      pc_reg    <= redirect_pc_i;
      if (imem_req_o && !imem_ack_i) begin
        state_reg <= DISCARD;
        if (state_reg == REQ) discard_addr_reg <= pc_reg;
      end else begin
        state_reg <= REQ;
      end
    end else begin
      // Decode consumed the current output unless it is stalling; later branches may overwrite.
      if (!stall_i) begin
        valid_o   <= 1'b0;
        instr_o   <= '0;
        next_pc_o <= '0;
      end
      case (state_reg)
        IDLE: state_reg <= REQ;
        REQ: begin
          if (imem_ack_i) begin
            pc_reg <= pc_inc;
            if (out_stalled) begin
              state_reg <= HOLD;
            end else begin
              valid_o   <= 1'b1;
              instr_o   <= imem_rdata_i;
              next_pc_o <= pc_inc;
            end
          end
        end
        HOLD: begin
          if (!stall_i) begin
            valid_o   <= skid_full;
            instr_o   <= skid_instr;
            next_pc_o <= skid_next_pc;
            state_reg <= REQ;
          end
        end
        DISCARD: begin
          if (imem_ack_i) state_reg <= REQ;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: memory returns addr+1, second instance exercises PC wrap.
module tb_fetch_unit;
  import fetch_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        stall_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [15:0] redirect_pc_i = 16'h0000;
  logic        ack_en = 1'b1;

  logic        req, req2, ack, ack2, valid, valid2;
  logic [15:0] addr, addr2, npc, npc2;
  logic [23:0] rdata, rdata2, instr, instr2;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk_i = ~clk_i;

  assign ack    = req && ack_en;
  assign ack2   = req2 && ack_en;
  assign rdata  = 24'(addr) + 24'd1;
  assign rdata2 = 24'(addr2) + 24'd1;

  fetch_unit #(.IWIDTH(24), .PWIDTH(16), .RESET_PC(16'h0000)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .imem_req_o(req), .imem_addr_o(addr), .imem_ack_i(ack), .imem_rdata_i(rdata),
    .stall_i(stall_i), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .valid_o(valid), .instr_o(instr), .next_pc_o(npc)
  );

  fetch_unit #(.IWIDTH(24), .PWIDTH(16), .RESET_PC(16'hFFFF)) dut_wrap (
    .clk_i(clk_i), .rst_i(rst_i),
    .imem_req_o(req2), .imem_addr_o(addr2), .imem_ack_i(ack2), .imem_rdata_i(rdata2),
    .stall_i(stall_i), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .valid_o(valid2), .instr_o(instr2), .next_pc_o(npc2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) begin
      n_pass++;
      $display("ok   %-18s got=%0h", tag, got);
    end else begin
      $display("FAIL %-18s got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [23:0] i, input logic [15:0] p);
    chk({tag, ".valid"}, 32'(valid), 32'(v));
    chk({tag, ".instr"}, 32'(instr), 32'(i));
    chk({tag, ".npc"},   32'(npc),   32'(p));
  endtask

  initial begin
    // Reset state
    @(negedge clk_i);
    @(negedge clk_i);
    chk("rst.req",   32'(req),   32'h0);
    chk("rst.addr",  32'(addr),  32'h0);
    chk_out("rst", 1'b0, 24'h0, 16'h0);
    chk("rst.addr2", 32'(addr2), 32'hFFFF);

    // Zero-wait streaming from address 0
    rst_i = 1'b1;
    step();
    chk("e1.req",  32'(req),  32'h1);
    chk("e1.addr", 32'(addr), 32'h0);
    chk("e1.valid", 32'(valid), 32'h0);
    step();
    chk_out("e2", 1'b1, 24'h000001, 16'h0001);
    chk("w.npc",   32'(npc2),   32'h0000);
    chk("w.instr", 32'(instr2), 32'h010000);
    chk("w.addr",  32'(addr2),  32'h0000);
    step();
    chk_out("e3", 1'b1, 24'h000002, 16'h0002);
    chk("w2.npc",  32'(npc2),  32'h0001);
    step();
    chk_out("e4", 1'b1, 24'h000003, 16'h0003);

    // Stall for 3 edges while the fetch of address 3 is acked
    stall_i = 1'b1;
    step();
    chk("st1.req", 32'(req), 32'h0);
    chk_out("st1", 1'b1, 24'h000003, 16'h0003);
    step();
    step();
    chk_out("st3", 1'b1, 24'h000003, 16'h0003);
    stall_i = 1'b0;
    step();
    chk_out("unstall", 1'b1, 24'h000004, 16'h0004);
    chk("unstall.addr", 32'(addr), 32'h0004);
    step();
    chk_out("after", 1'b1, 24'h000005, 16'h0005);
    chk("pend.addr", 32'(addr), 32'h0005);

    // Redirect while address 5 is outstanding with 2-cycle latency
    ack_en = 1'b0;
    redirect_i = 1'b1;
    redirect_pc_i = 16'h0040;
    step();
    redirect_i = 1'b0;
    chk("disc.req",  32'(req),  32'h1);
    chk("disc.addr", 32'(addr), 32'h0005);
    chk("disc.valid", 32'(valid), 32'h0);
    ack_en = 1'b1;
    step();
    chk("drop.valid", 32'(valid), 32'h0);
    chk("new.addr",   32'(addr),  32'h0040);
    step();
    chk_out("redir", 1'b1, 24'h000041, 16'h0041);

    // Redirect together with stall and a valid output
    stall_i = 1'b1;
    redirect_i = 1'b1;
    redirect_pc_i = 16'h0080;
    step();
    chk_out("rs", 1'b0, 24'h0, 16'h0);
    chk("rs.addr", 32'(addr), 32'h0080);
    stall_i = 1'b0;
    redirect_i = 1'b0;
    step();
    chk_out("rs2", 1'b1, 24'h000081, 16'h0081);

    // Asynchronous reset with a request pending
    ack_en = 1'b0;
    #2;
    rst_i = 1'b0;
    #1;
    chk("arst.req",  32'(req),  32'h0);
    chk("arst.addr", 32'(addr), 32'h0);
    chk_out("arst", 1'b0, 24'h0, 16'h0);
    @(negedge clk_i);
    ack_en = 1'b1;
    rst_i = 1'b1;
    step();
    chk("rel.addr", 32'(addr), 32'h0);
    chk("rel.req",  32'(req),  32'h1);
    step();
    chk_out("rel", 1'b1, 24'h000001, 16'h0001);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
